// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write and read controllers.
//   FIFO_ADDR_W : default RAM address width (depth = 2**FIFO_ADDR_W)
//   PTR_MAX_W   : widest pointer the conversion helpers accept; callers
//                 zero-extend into it and size-cast the result back down
//   bin2gray    : binary -> reflected Gray
//   gray2bin    : reflected Gray -> binary
package fifo_pkg;

  localparam int FIFO_ADDR_W = 3;
  localparam int PTR_MAX_W   = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. Leading zero
  // bits from zero-extension leave the result unchanged.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write pointer register, Gray conversion and full detection.
// Ports:
//   wclk, wrst  : write clock, asynchronous active-high reset
//   winc        : write request from the producer
//   wq2_rptr    : Gray read pointer, already synchronized into wclk
//   wen         : RAM write enable (combinational)
//   waddr       : RAM write address (low bits of the binary pointer)
//   wbin_next   : binary pointer after this cycle's accept (combinational)
//   wptr        : registered Gray write pointer for the read-side synchronizer
//   wfull       : registered full flag
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wbin_next,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull
);

  localparam int PTR_W = ADDR_W + 1;

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] full_pattern;

  // A write is taken exactly when the producer requests and we are not full;
  // a request while full is dropped, never stalled.
  assign wen       = winc & ~wfull;
  assign waddr     = wbin[ADDR_W-1:0];
  assign wbin_next = wbin + {{ADDR_W{1'b0}}, wen};

  assign wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code that is the read pointer with its top two bits inverted.
  assign full_pattern = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      // Compared against the next pointer so full rises on the same edge that
      // stores the last entry.
      wfull <= (wgray_next == full_pattern);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO.
// Owns the write pointer, drives the RAM write port, and reports full,
// almost-full, fill level and a sticky overflow flag to the producer.
// Ports:
//   wclk, wrst   : write clock, asynchronous active-high reset
//   winc         : write request
//   wq2_rptr     : Gray read pointer, 2-FF synchronized into wclk
//   wovf_clr     : clears the sticky overflow flag
//   wen, waddr   : RAM write enable / address
//   wptr         : registered Gray write pointer to the read side
//   wfull        : registered full
//   walmost_full : registered, fill level >= AFULL_TH
//   wcount       : registered fill level 0..2**ADDR_W
//   woverflow    : sticky, a write was attempted while full
//
// Handshake: there is no backpressure wait state. In any cycle with winc=1
// the write is accepted (wen=1) if wfull=0, otherwise it is discarded and
// woverflow is set. The producer is expected to watch wfull/walmost_full.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AFULL_TH = 6
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  input  logic              wovf_clr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wcount,
  output logic              woverflow
);

  localparam int              PTR_W     = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_LVL = PTR_W'(AFULL_TH);

  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] level_next;

  fifo_wptr_full #(
    .ADDR_W (ADDR_W)
  ) u_wptr_full (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .wen       (wen),
    .waddr     (waddr),
    .wbin_next (wbin_next),
    .wptr      (wptr),
    .wfull     (wfull)
  );

  assign rbin_s = PTR_W'(gray2bin(PTR_MAX_W'(wq2_rptr)));

  // Modular difference of the wrap-bit pointers gives 0..2**ADDR_W directly,
  // across both the address wrap and the pointer wrap.
  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wcount       <= '0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wcount       <= level_next;
      walmost_full <= (level_next >= AFULL_LVL);
      // A rejected write outranks a clear in the same cycle.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

  localparam int ADDR_W   = 3;
  localparam int AFULL_TH = 6;

  logic              wclk;
  logic              wrst;
  logic              winc;
  logic [ADDR_W:0]   wq2_rptr;
  logic              wovf_clr;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wcount;
  logic              woverflow;

  fifo_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  // ---------------- clock ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  // Expected registered outputs: {wptr[3:0], wfull, walmost_full, wcount[3:0], woverflow}
  logic [10:0] exp_q[$];

  // Reference model state (binary write pointer, full, overflow)
  logic [3:0] m_wbin;
  logic       m_full;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wbin = 4'd0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus. The read pointer is given in binary and driven as
  // Gray. Full is modelled from the fill level, not from a Gray compare.
  task automatic step(input logic inc, input logic clr, input logic [3:0] rptr_bin);
    logic       acc;
    logic [3:0] nb;
    logic [3:0] lvl;
    logic [10:0] e;
    @(negedge wclk);
    winc     = inc;
    wovf_clr = clr;
    wq2_rptr = to_gray(rptr_bin);
    acc = inc && !m_full;
    #1;
    check("wen", {31'd0, wen}, {31'd0, acc});
    check("waddr", {29'd0, waddr}, {29'd0, m_wbin[2:0]});
    nb  = m_wbin + {3'd0, acc};
    lvl = nb - rptr_bin;
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_wbin = nb;
    m_full = (lvl == 4'd8);
    exp_q.push_back({to_gray(nb), m_full, (lvl >= 4'd6), lvl, m_ovf});
    @(posedge wclk);
    #1;
    e = exp_q.pop_front();
    check("wptr", {28'd0, wptr}, {28'd0, e[10:7]});
    check("wfull", {31'd0, wfull}, {31'd0, e[6]});
    check("walmost_full", {31'd0, walmost_full}, {31'd0, e[5]});
    check("wcount", {28'd0, wcount}, {28'd0, e[4:1]});
    check("woverflow", {31'd0, woverflow}, {31'd0, e[0]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"}, {28'd0, wptr}, 32'd0);
    check({tag, "_wfull"}, {31'd0, wfull}, 32'd0);
    check({tag, "_walmost_full"}, {31'd0, walmost_full}, 32'd0);
    check({tag, "_wcount"}, {28'd0, wcount}, 32'd0);
    check({tag, "_woverflow"}, {31'd0, woverflow}, 32'd0);
    check({tag, "_waddr"}, {29'd0, waddr}, 32'd0);
    check({tag, "_wen"}, {31'd0, wen}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    wrst     = 1'b1;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge wclk);
    wrst = 1'b0;

    // 1. fill 8 entries with the reader idle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'd0);
      if (i == 5) check("t1_af_after_6", {31'd0, walmost_full}, 32'd1);
      if (i == 4) check("t1_af_after_5", {31'd0, walmost_full}, 32'd0);
    end
    check("t1_wptr_full", {28'd0, wptr}, 32'hC);
    check("t1_wfull", {31'd0, wfull}, 32'd1);
    check("t1_wcount", {28'd0, wcount}, 32'd8);

    // 2. writes while full are rejected and flagged; then clear
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    check("t2_wptr_hold", {28'd0, wptr}, 32'hC);
    check("t2_ovf", {31'd0, woverflow}, 32'd1);
    step(1'b0, 1'b1, 4'd0);
    check("t2_ovf_clr", {31'd0, woverflow}, 32'd0);

    // 3. reader advances to 3
    step(1'b0, 1'b0, 4'd3);
    check("t3_wfull", {31'd0, wfull}, 32'd0);
    check("t3_wcount", {28'd0, wcount}, 32'd5);
    check("t3_af", {31'd0, walmost_full}, 32'd0);

    // 4. 20 writes with the reader trailing two behind: crosses both wraps
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, m_wbin - 4'd1);
      check("t4_wcount2", {28'd0, wcount}, 32'd2);
    end

    // 5. asynchronous reset mid-burst at level 5
    @(negedge wclk);
    wrst = 1'b1;
    winc = 1'b0;
    wq2_rptr = '0;
    model_reset();
    @(negedge wclk);
    wrst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0);
    check("t5_wcount5", {28'd0, wcount}, 32'd5);
    @(posedge wclk);
    #2;
    wrst = 1'b1;
    winc = 1'b0;
    #1;
    check_all_zero("t5_async");
    model_reset();
    @(negedge wclk);
    wrst = 1'b0;
    step(1'b1, 1'b0, 4'd0);
    check("t5_first_ptr", {28'd0, wptr}, 32'd1);

    // 6. clear coinciding with a rejected write: set wins
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'd0);
    check("t6_full", {31'd0, wfull}, 32'd1);
    step(1'b1, 1'b1, 4'd0);
    check("t6_ovf_set_wins", {31'd0, woverflow}, 32'd1);
    step(1'b0, 1'b1, 4'd0);
    check("t6_ovf_cleared", {31'd0, woverflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
